vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, VRAM byte-address width (64x32 display, 8 bytes/row).
REQ-002 SHALL have parameter READ_LATENCY, default 2, VRAM read latency in cycles.
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-005 SHALL have port hdmi_req_in  input  1  HDMI read strobe, one per cycle, never stalled.
REQ-006 SHALL have port hdmi_addr_in  input  16  HDMI byte address; bits above ADDR_W ignored.
REQ-007 SHALL have port hdmi_data_out  output  8  HDMI read data.
REQ-008 SHALL have port hdmi_valid_out  output  1  hdmi_data_out valid.
REQ-009 SHALL have ports cpu_valid_in (input 1), cpu_we_in (input 1), cpu_addr_in (input ADDR_W), cpu_wdata_in (input 8): CPU request.
REQ-010 SHALL have ports cpu_ready_out (output 1), cpu_rdata_out (output 8), cpu_rvalid_out (output 1): CPU accept and read return.
REQ-011 SHALL have ports clear_start_in (input 1), clear_busy_out (output 1), clear_done_out (output 1): screen-clear control.
REQ-012 SHALL have ports vram_addr_out (output ADDR_W), vram_we_out (output 1), vram_wdata_out (output 8), vram_rdata_in (input 8): single-port VRAM.

Function
REQ-013 SHALL grant the VRAM port each cycle by fixed priority: HDMI > clear engine > CPU.
REQ-014 SHALL drive vram_* combinationally from the granted source; no grant -> vram_we_out=0, vram_addr_out=0.
REQ-015 SHALL return HDMI read data with hdmi_valid_out high exactly READ_LATENCY+... i.e. READ_LATENCY cycles after hdmi_req_in, independent of CPU/clear activity.
REQ-016 SHALL assert cpu_ready_out = !hdmi_req_in && !clear_busy_out (combinational); transfer occurs when cpu_valid_in && cpu_ready_out.
REQ-017 SHALL not require cpu_valid_in to drop between transfers; back-to-back CPU transfers at 1/cycle allowed.
REQ-018 SHALL, for an accepted CPU read, pulse cpu_rvalid_out for one cycle with cpu_rdata_out exactly READ_LATENCY cycles after acceptance; CPU writes produce no rvalid.
REQ-019 SHALL track in-flight reads with a READ_LATENCY-deep pipeline of {hdmi, cpu} tag bits; at most one tag set per stage.
REQ-020 SHALL hold hdmi_data_out/cpu_rdata_out at last returned value when their valid is low.
REQ-021 SHALL implement clear FSM states IDLE, CLEAR, DONE: IDLE->CLEAR on clear_start_in; CLEAR writes 0x00 to addresses 0..2^ADDR_W-1 in order, advancing only on cycles not granted to HDMI; CLEAR->DONE after writing the last address; DONE->IDLE next cycle.
REQ-022 SHALL assert clear_busy_out in CLEAR and DONE; clear_done_out is a one-cycle pulse in DONE.
REQ-023 SHALL ignore clear_start_in while clear_busy_out is high.
REQ-024 SHALL, if clear_start_in and cpu_valid_in coincide in IDLE, accept the CPU transfer that cycle (ready computed pre-transition), then start CLEAR next cycle.
REQ-025 SHALL use an ADDR_W+1-bit clear counter so the final address terminates without wrap to 0.

Reset
REQ-026 SHALL on rst_in: FSM->IDLE, clear counter=0, all tag bits=0, hdmi_valid_out=0, cpu_rvalid_out=0, hdmi_data_out=0, cpu_rdata_out=0, clear_busy_out=0, clear_done_out=0.
REQ-027 SHALL discard reads in flight at reset; no valid pulses for them afterwards.
REQ-028 SHALL abort a clear mid-operation on reset with no done pulse.

Configuration
REQ-029 SHALL compile the clear engine only when VRAM_ARBITER_CLEAR_EN is defined; without it clear_start_in is ignored, clear_busy_out and clear_done_out tie to 0, priority is HDMI > CPU.

Structure
REQ-030 SHALL place clear FSM state enum, VRAM depth constant and default READ_LATENCY in shared package vram_pkg.
REQ-031 SHALL implement the read-tag/data return pipeline as sub-module vram_read_tracker; arbiter and FSM stay in vram_arbiter.

Verification
REQ-032 SHALL cover: HDMI req addr 0x05 every cycle, VRAM[5]=0xA5 -> hdmi_valid_out every cycle from cycle 2, data 0xA5, cpu_ready_out=0 throughout.
REQ-033 SHALL cover: CPU write 0x3C to 0x10 then read 0x10, no HDMI -> cpu_rvalid_out 2 cycles after read accept, rdata 0x3C.
REQ-034 SHALL cover: CPU valid held while HDMI req alternates 1/0 -> CPU accepted only on HDMI-idle cycles; HDMI and CPU returns never collide.
REQ-035 SHALL cover: clear_start pulse, no HDMI -> 256 writes of 0x00, clear_done_out 257 cycles after start; all reads then 0x00.
REQ-036 SHALL cover: rst_in asserted at clear address 0x80 with CPU read in flight -> no done, no rvalid; outputs at reset values next cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter slice: default geometry,
// default read latency, clear-engine state encoding and the read tag record.
package vram_pkg;

    // 64x32 one-bit-per-pixel display packed 8 pixels per byte
    localparam int DEFAULT_ADDR_W       = 8;
    localparam int VRAM_DEPTH           = 1 << DEFAULT_ADDR_W;
    localparam int DEFAULT_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clear_state_t;

    // One pipeline stage of in-flight read ownership; at most one bit is set
    typedef struct packed {
        logic hdmi;
        logic cpu;
    } read_tag_t;

endpackage

// File: rtl/vram_read_tracker.sv
// Follows each issued VRAM read through a READ_LATENCY-deep tag pipeline and
// steers the returning byte to the HDMI or CPU side. Each side's data output
// keeps its last returned byte while its valid is low.
module vram_read_tracker
    import vram_pkg::*;
#(
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hdmi_issue,
    input  logic       cpu_issue,
    input  logic [7:0] rdata,
    output logic [7:0] hdmi_data,
    output logic       hdmi_valid,
    output logic [7:0] cpu_data,
    output logic       cpu_valid
);

    read_tag_t  tags [READ_LATENCY];
    read_tag_t  new_tag;
    read_tag_t  ret_tag;
    logic [7:0] hdmi_hold;
    logic [7:0] cpu_hold;

    // HDMI wins the port, so a CPU tag is never recorded alongside an HDMI tag
    assign new_tag.hdmi = hdmi_issue;
    assign new_tag.cpu  = cpu_issue && !hdmi_issue;
    assign ret_tag      = tags[READ_LATENCY-1];

    // Shift the ownership tags one stage per cycle; reset drops all in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    // Remember the last byte delivered to each side so it can be held afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            hdmi_hold <= 8'h00;
            cpu_hold  <= 8'h00;
        end else begin
            if (ret_tag.hdmi) begin
                hdmi_hold <= rdata;
            end
            if (ret_tag.cpu) begin
                cpu_hold <= rdata;
            end
        end
    end

    assign hdmi_valid = ret_tag.hdmi;
    assign cpu_valid  = ret_tag.cpu;
    assign hdmi_data  = ret_tag.hdmi ? rdata : hdmi_hold;
    assign cpu_data   = ret_tag.cpu  ? rdata : cpu_hold;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: HDMI scan-out reads, an optional screen-clear
// engine and CPU reads/writes share one port under fixed priority
// HDMI > clear > CPU. HDMI is never stalled; the CPU is back-pressured.
// Build option: define VRAM_ARBITER_CLEAR_EN to include the clear engine;
// without it clear_start_in is ignored and clear_busy/done stay low.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic              clk_in,
    input  logic              rst_in,

    input  logic              hdmi_req_in,
    input  logic [15:0]       hdmi_addr_in,
    output logic [7:0]        hdmi_data_out,
    output logic              hdmi_valid_out,

    input  logic              cpu_valid_in,
    input  logic              cpu_we_in,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic [7:0]        cpu_wdata_in,
    output logic              cpu_ready_out,
    output logic [7:0]        cpu_rdata_out,
    output logic              cpu_rvalid_out,

    input  logic              clear_start_in,
    output logic              clear_busy_out,
    output logic              clear_done_out,

    output logic [ADDR_W-1:0] vram_addr_out,
    output logic              vram_we_out,
    output logic [7:0]        vram_wdata_out,
    input  logic [7:0]        vram_rdata_in
);

    logic [ADDR_W-1:0] hdmi_addr;
    logic              unused_hdmi_addr;
    logic              clear_grant;
    logic              clear_busy;
    logic              clear_done;
    logic [ADDR_W-1:0] clear_addr;
    logic              cpu_ready;
    logic              cpu_fire;
    logic              cpu_read_issue;

    // Only the low ADDR_W bits of the HDMI address select a byte
    assign hdmi_addr        = hdmi_addr_in[ADDR_W-1:0];
    assign unused_hdmi_addr = ^hdmi_addr_in;

`ifdef VRAM_ARBITER_CLEAR_EN

    clear_state_t      state;
    clear_state_t      state_next;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W:0]   count_inc;

    // The extra counter bit flags completion so the last address never wraps to 0
    assign count_inc  = count + 1'b1;
    assign clear_addr = count[ADDR_W-1:0];

    // Clear engine state and address counter
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= CLR_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Clear sequencing: write zeros whenever HDMI leaves the port free, then pulse done
    always_comb begin
        state_next  = state;
        count_next  = count;
        clear_grant = 1'b0;
        clear_busy  = 1'b0;
        clear_done  = 1'b0;
        case (state)
            CLR_IDLE: begin
                if (clear_start_in) begin
                    state_next = CLR_CLEAR;
                    count_next = '0;
                end
            end
            CLR_CLEAR: begin
                clear_busy = 1'b1;
                if (!hdmi_req_in) begin
                    clear_grant = 1'b1;
                    count_next  = count_inc;
                    if (count_inc[ADDR_W]) begin
                        state_next = CLR_DONE;
                    end
                end
            end
            CLR_DONE: begin
                clear_busy = 1'b1;
                clear_done = 1'b1;
                state_next = CLR_IDLE;
            end
            default: begin
                state_next = CLR_IDLE;
            end
        endcase
    end

`else

    logic unused_clear_start;

    assign unused_clear_start = clear_start_in;
    assign clear_grant        = 1'b0;
    assign clear_busy         = 1'b0;
    assign clear_done         = 1'b0;
    assign clear_addr         = '0;

`endif

    // The CPU may only proceed when neither HDMI nor an active clear owns the port
    assign cpu_ready      = !hdmi_req_in && !clear_busy;
    assign cpu_fire       = cpu_valid_in && cpu_ready;
    assign cpu_read_issue = cpu_fire && !cpu_we_in;

    assign cpu_ready_out  = cpu_ready;
    assign clear_busy_out = clear_busy;
    assign clear_done_out = clear_done;

    // Steer the VRAM port from the winning requester; an idle port reads address 0
    always_comb begin
        vram_addr_out  = '0;
        vram_we_out    = 1'b0;
        vram_wdata_out = 8'h00;
        if (hdmi_req_in) begin
            vram_addr_out = hdmi_addr;
        end else if (clear_grant) begin
            vram_addr_out  = clear_addr;
            vram_we_out    = 1'b1;
            vram_wdata_out = 8'h00;
        end else if (cpu_fire) begin
            vram_addr_out  = cpu_addr_in;
            vram_we_out    = cpu_we_in;
            vram_wdata_out = cpu_wdata_in;
        end
    end

    vram_read_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tracker (
        .clk        (clk_in),
        .rst        (rst_in),
        .hdmi_issue (hdmi_req_in),
        .cpu_issue  (cpu_read_issue),
        .rdata      (vram_rdata_in),
        .hdmi_data  (hdmi_data_out),
        .hdmi_valid (hdmi_valid_out),
        .cpu_data   (cpu_rdata_out),
        .cpu_valid  (cpu_rvalid_out)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 2-cycle-latency VRAM.
// Clear-engine sequences are built when VRAM_ARBITER_CLEAR_EN is defined.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int ADDR_W = 8;
    localparam int RL     = 2;

    logic              clk_in;
    logic              rst_in;
    logic              hdmi_req_in;
    logic [15:0]       hdmi_addr_in;
    logic [7:0]        hdmi_data_out;
    logic              hdmi_valid_out;
    logic              cpu_valid_in;
    logic              cpu_we_in;
    logic [ADDR_W-1:0] cpu_addr_in;
    logic [7:0]        cpu_wdata_in;
    logic              cpu_ready_out;
    logic [7:0]        cpu_rdata_out;
    logic              cpu_rvalid_out;
    logic              clear_start_in;
    logic              clear_busy_out;
    logic              clear_done_out;
    logic [ADDR_W-1:0] vram_addr_out;
    logic              vram_we_out;
    logic [7:0]        vram_wdata_out;
    logic [7:0]        vram_rdata_in;

    int n_checks;
    int n_fail;

    logic       init_mem;
    logic [7:0] mem [VRAM_DEPTH];
    logic [7:0] rd_pipe1;
    logic [7:0] rd_pipe2;

    typedef struct {
        string      name;
        logic       hdmi_req;
        logic [15:0] hdmi_addr;
        logic       cpu_valid;
        logic       cpu_we;
        logic [7:0] cpu_addr;
        logic [7:0] cpu_wdata;
        logic [7:0] exp_addr;
        logic       exp_we;
        logic [7:0] exp_wdata;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [7];

    vram_arbiter #(
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hdmi_req_in    (hdmi_req_in),
        .hdmi_addr_in   (hdmi_addr_in),
        .hdmi_data_out  (hdmi_data_out),
        .hdmi_valid_out (hdmi_valid_out),
        .cpu_valid_in   (cpu_valid_in),
        .cpu_we_in      (cpu_we_in),
        .cpu_addr_in    (cpu_addr_in),
        .cpu_wdata_in   (cpu_wdata_in),
        .cpu_ready_out  (cpu_ready_out),
        .cpu_rdata_out  (cpu_rdata_out),
        .cpu_rvalid_out (cpu_rvalid_out),
        .clear_start_in (clear_start_in),
        .clear_busy_out (clear_busy_out),
        .clear_done_out (clear_done_out),
        .vram_addr_out  (vram_addr_out),
        .vram_we_out    (vram_we_out),
        .vram_wdata_out (vram_wdata_out),
        .vram_rdata_in  (vram_rdata_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_value(int i);
        if (i == 5) return 8'hA5;
        return 8'(i) ^ 8'h5A;
    endfunction

    // Behavioural single-port VRAM: data appears two cycles after the address
    always @(posedge clk_in) begin
        if (init_mem) begin
            for (int i = 0; i < VRAM_DEPTH; i++) mem[i] <= init_value(i);
        end else if (vram_we_out) begin
            mem[vram_addr_out] <= vram_wdata_out;
        end
        rd_pipe1 <= mem[vram_addr_out];
        rd_pipe2 <= rd_pipe1;
    end
    assign vram_rdata_in = rd_pipe2;

    task automatic nextCycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic hreq, input logic [15:0] haddr,
                                 input logic cval, input logic cwe,
                                 input logic [7:0] caddr, input logic [7:0] cwdata,
                                 input logic cstart);
        hdmi_req_in    = hreq;
        hdmi_addr_in   = haddr;
        cpu_valid_in   = cval;
        cpu_we_in      = cwe;
        cpu_addr_in    = caddr;
        cpu_wdata_in   = cwdata;
        clear_start_in = cstart;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       h_iss [16];
        logic       c_iss [16];
        logic [7:0] c_dat [16];
        logic [7:0] next_addr;
        logic       hreq;
        logic       exp_ready;

        n_checks = 0;
        n_fail   = 0;

        // fields: name, hdmi_req, hdmi_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        //         exp_addr, exp_we, exp_wdata, exp_ready
        vecs[0] = '{"idle",            1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{"hdmi_addr_trunc", 1'b1, 16'h0123, 1'b0, 1'b0, 8'h00, 8'h00, 8'h23, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{"hdmi_beats_cpu",  1'b1, 16'h0040, 1'b1, 1'b1, 8'h55, 8'hEE, 8'h40, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{"cpu_write",       1'b0, 16'h0000, 1'b1, 1'b1, 8'h90, 8'h77, 8'h90, 1'b1, 8'h77, 1'b1};
        vecs[4] = '{"cpu_read",        1'b0, 16'h0000, 1'b1, 1'b0, 8'h91, 8'h00, 8'h91, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{"cpu_not_valid",   1'b0, 16'h0000, 1'b0, 1'b1, 8'h33, 8'h44, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{"hdmi_addr_max",   1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0};

        // Reset with memory preload
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst_in   = 1'b1;
        init_mem = 1'b1;
        repeat (3) nextCycle();
        rst_in   = 1'b0;
        init_mem = 1'b0;
        #1;
        checkOutput("rst_hdmi_valid", 16'(hdmi_valid_out), 16'h0);
        checkOutput("rst_cpu_rvalid", 16'(cpu_rvalid_out), 16'h0);
        checkOutput("rst_hdmi_data",  16'(hdmi_data_out),  16'h0);
        checkOutput("rst_cpu_rdata",  16'(cpu_rdata_out),  16'h0);
        checkOutput("rst_busy",       16'(clear_busy_out), 16'h0);
        checkOutput("rst_done",       16'(clear_done_out), 16'h0);
        checkOutput("rst_ready",      16'(cpu_ready_out),  16'h1);

        // Table: combinational grant and port steering
        for (int v = 0; v < 7; v++) begin
            nextCycle();
            applyStimulus(vecs[v].hdmi_req, vecs[v].hdmi_addr, vecs[v].cpu_valid,
                          vecs[v].cpu_we, vecs[v].cpu_addr, vecs[v].cpu_wdata, 1'b0);
            #1;
            checkOutput({vecs[v].name, "_addr"},  16'(vram_addr_out), 16'(vecs[v].exp_addr));
            checkOutput({vecs[v].name, "_we"},    16'(vram_we_out),   16'(vecs[v].exp_we));
            checkOutput({vecs[v].name, "_ready"}, 16'(cpu_ready_out), 16'(vecs[v].exp_ready));
            if (vecs[v].exp_we)
                checkOutput({vecs[v].name, "_wdata"}, 16'(vram_wdata_out), 16'(vecs[v].exp_wdata));
        end
        idle(4);

        // HDMI streaming address 5 every cycle with the CPU waiting
        for (int c = 0; c < 12; c++) begin
            nextCycle();
            applyStimulus(c < 8, 16'h0005, c < 8, 1'b0, 8'h40, 8'h00, 1'b0);
            #1;
            if (c < 8) checkOutput("stream_ready", 16'(cpu_ready_out), 16'h0);
            checkOutput("stream_hvalid", 16'(hdmi_valid_out), 16'(c >= 2 && c < 10));
            if (c >= 2) checkOutput("stream_hdata", 16'(hdmi_data_out), 16'hA5);
            checkOutput("stream_no_rvalid", 16'(cpu_rvalid_out), 16'h0);
        end

        // CPU write then read-back of the same byte
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            if (c == 0)      applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 8'h10, 8'h3C, 1'b0);
            else if (c == 1) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
            else             applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            #1;
            if (c < 2) checkOutput("wr_rd_ready", 16'(cpu_ready_out), 16'h1);
            checkOutput("wr_rd_rvalid", 16'(cpu_rvalid_out), 16'(c == 3));
            if (c >= 3) checkOutput("wr_rd_rdata", 16'(cpu_rdata_out), 16'h3C);
        end

        // CPU held valid while HDMI alternates; scoreboard of issued reads
        for (int i = 0; i < 16; i++) begin
            h_iss[i] = 1'b0; c_iss[i] = 1'b0; c_dat[i] = 8'h00;
        end
        next_addr = 8'h20;
        for (int c = 0; c < 14; c++) begin
            nextCycle();
            hreq      = (c < 10) && (c % 2 == 0);
            exp_ready = !hreq;
            applyStimulus(hreq, 16'h0005, c < 10, 1'b0, next_addr, 8'h00, 1'b0);
            #1;
            checkOutput("alt_ready", 16'(cpu_ready_out), 16'(exp_ready));
            h_iss[c] = hreq;
            if (c < 10 && exp_ready) begin
                c_iss[c]  = 1'b1;
                c_dat[c]  = init_value(int'(next_addr));
                next_addr = next_addr + 8'h01;
            end
            if (c >= 2) begin
                checkOutput("alt_hvalid", 16'(hdmi_valid_out), 16'(h_iss[c-2]));
                checkOutput("alt_rvalid", 16'(cpu_rvalid_out), 16'(c_iss[c-2]));
                if (c_iss[c-2]) checkOutput("alt_rdata", 16'(cpu_rdata_out), 16'(c_dat[c-2]));
                if (h_iss[c-2]) checkOutput("alt_hdata", 16'(hdmi_data_out), 16'hA5);
            end
            checkOutput("alt_no_collide", 16'(hdmi_valid_out & cpu_rvalid_out), 16'h0);
        end
        idle(2);

        // Reset with an HDMI and a CPU read in flight
        nextCycle(); applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        nextCycle(); applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0);
        nextCycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst_in = 1'b1;
        #1;
        checkOutput("pre_rst_hvalid", 16'(hdmi_valid_out), 16'h1);
        checkOutput("pre_rst_hdata",  16'(hdmi_data_out),  16'hA5);
        nextCycle();
        rst_in = 1'b0;
        #1;
        checkOutput("post_rst_hvalid", 16'(hdmi_valid_out), 16'h0);
        checkOutput("post_rst_rvalid", 16'(cpu_rvalid_out), 16'h0);
        checkOutput("post_rst_hdata",  16'(hdmi_data_out),  16'h0);
        checkOutput("post_rst_rdata",  16'(cpu_rdata_out),  16'h0);
        nextCycle(); #1;
        checkOutput("post_rst_rvalid2", 16'(cpu_rvalid_out), 16'h0);
        idle(2);

`ifdef VRAM_ARBITER_CLEAR_EN
        begin
            int   found_cycle;
            int   done_cycle;
            int   done_count;
            int   writes;
            int   bad_data;
            int   c;
            logic [7:0] rb_addr [5];

            // Start coincides with a CPU read: CPU goes first, clear follows
            nextCycle();
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1);
            #1;
            checkOutput("coinc_ready", 16'(cpu_ready_out), 16'h1);
            checkOutput("coinc_addr",  16'(vram_addr_out), 16'h30);
            checkOutput("coinc_we",    16'(vram_we_out),   16'h0);
            nextCycle();
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            #1;
            checkOutput("coinc_busy",     16'(clear_busy_out), 16'h1);
            checkOutput("coinc_clr_we",   16'(vram_we_out),    16'h1);
            checkOutput("coinc_clr_addr", 16'(vram_addr_out),  16'h0);
            nextCycle(); #1;
            checkOutput("coinc_rvalid", 16'(cpu_rvalid_out), 16'h1);
            checkOutput("coinc_rdata",  16'(cpu_rdata_out),  16'h6A);

            // Abort that clear with reset while it writes address 0x80
            found_cycle = 0;
            c = 2;
            while (found_cycle == 0 && c < 300) begin
                nextCycle(); #1;
                c++;
                if (vram_we_out && vram_addr_out == 8'h80) found_cycle = c;
            end
            checkOutput("abort_at_0x80", 16'(found_cycle), 16'd129);
            rst_in = 1'b1;
            nextCycle();
            rst_in = 1'b0;
            #1;
            checkOutput("abort_busy",   16'(clear_busy_out), 16'h0);
            checkOutput("abort_done",   16'(clear_done_out), 16'h0);
            checkOutput("abort_rvalid", 16'(cpu_rvalid_out), 16'h0);
            checkOutput("abort_rdata",  16'(cpu_rdata_out),  16'h0);
            done_count = 0;
            for (int i = 0; i < 300; i++) begin
                nextCycle(); #1;
                if (clear_done_out) done_count++;
            end
            checkOutput("abort_no_done", 16'(done_count), 16'h0);

            // Full clear with a short HDMI burst and an ignored restart
            nextCycle();
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
            done_cycle = 0; writes = 0; bad_data = 0;
            c = 0;
            while (done_cycle == 0 && c < 400) begin
                nextCycle();
                c++;
                applyStimulus(c >= 10 && c < 15, 16'h0005, 1'b0, 1'b0, 8'h00, 8'h00, c == 50);
                #1;
                if (vram_we_out) begin
                    writes++;
                    if (vram_wdata_out != 8'h00) bad_data++;
                end
                if (c == 12) begin
                    checkOutput("clr_hdmi_addr", 16'(vram_addr_out), 16'h05);
                    checkOutput("clr_hdmi_we",   16'(vram_we_out),   16'h0);
                end
                if (c == 1 || c == 200) begin
                    checkOutput("clr_busy",  16'(clear_busy_out), 16'h1);
                    checkOutput("clr_ready", 16'(cpu_ready_out),  16'h0);
                end
                if (clear_done_out) done_cycle = c;
            end
            checkOutput("clr_done_cycle", 16'(done_cycle), 16'd262);
            checkOutput("clr_writes",     16'(writes),     16'd256);
            checkOutput("clr_zero_data",  16'(bad_data),   16'd0);
            nextCycle(); #1;
            checkOutput("clr_after_busy", 16'(clear_busy_out), 16'h0);
            checkOutput("clr_after_done", 16'(clear_done_out), 16'h0);

            rb_addr[0] = 8'h00; rb_addr[1] = 8'h05; rb_addr[2] = 8'h10;
            rb_addr[3] = 8'h80; rb_addr[4] = 8'hFF;
            for (int k = 0; k < 7; k++) begin
                nextCycle();
                applyStimulus(1'b0, 16'h0, k < 5, 1'b0, (k < 5) ? rb_addr[k] : 8'h00, 8'h00, 1'b0);
                #1;
                if (k >= 2) begin
                    checkOutput("clr_rb_rvalid", 16'(cpu_rvalid_out), 16'h1);
                    checkOutput("clr_rb_rdata",  16'(cpu_rdata_out),  16'h00);
                end
            end
        end
`else
        // Without the clear engine the start input has no effect
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            applyStimulus(1'b0, 16'h0, c == 1, 1'b0, 8'h05, 8'h00, c == 0);
            #1;
            checkOutput("noclr_busy",  16'(clear_busy_out), 16'h0);
            checkOutput("noclr_done",  16'(clear_done_out), 16'h0);
            checkOutput("noclr_ready", 16'(cpu_ready_out),  16'h1);
            checkOutput("noclr_we",    16'(vram_we_out),    16'h0);
            if (c == 3) begin
                checkOutput("noclr_rvalid", 16'(cpu_rvalid_out), 16'h1);
                checkOutput("noclr_rdata",  16'(cpu_rdata_out),  16'hA5);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
